// File: rtl/image_grid_locator.sv
// Locates the current raster pixel within a COLS x ROWS grid of image tiles and
// produces the image ROM address plus a blinking red indicator overlay, 2 cycles later.
module image_grid_locator #(
  parameter int CNTR_WIDTH_H       = 10,
  parameter int CNTR_WIDTH_V       = 10,
  parameter int ROM_ADDR_BUS_WIDTH = 17,
  parameter int PIC_W              = 100,
  parameter int PIC_H              = 100,
  parameter int COLS               = 4,
  parameter int ROWS               = 3,
  parameter int X0                 = 308,
  parameter int Y0                 = 20,
  parameter int PITCH_X            = 128,
  parameter int PITCH_Y            = 128,
  parameter int IND_SIZE           = 10,
  parameter int BLINK_FRAMES       = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_valid,
  input  logic                          frame_start,
  input  logic [CNTR_WIDTH_H-1:0]       CounterX,
  input  logic [CNTR_WIDTH_V-1:0]       CounterY,
  input  logic [COLS*ROWS-1:0]          HighlightedProductList,
  input  logic                          blink_en,
  output logic                          out_valid,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr,
  output logic                          isImage,
  output logic [3:0]                    ImageID,
  output logic                          isHighlight,
  output logic [23:0]                   black_white
);

  localparam int N   = COLS * ROWS;
  localparam int LXW = $clog2(PIC_W + 1);
  localparam int LYW = $clog2(PIC_H + 1);
  localparam int BCW = $clog2(BLINK_FRAMES + 1);

  logic [31:0]      w_x, w_y;
  logic [COLS-1:0]  w_col_hits;
  logic [ROWS-1:0]  w_row_hits;
  logic [3:0]       w_col, w_row, w_id;
  logic [31:0]      w_lx, w_ly;
  logic             w_hit, w_ind, w_hl_on;

  logic [N-1:0]     r_shadow;
  logic [BCW-1:0]   r_blink_cnt;
  logic             r_blink_phase;

  logic             r_s1_valid, r_s1_hit, r_s1_ind, r_s1_hl;
  logic [3:0]       r_s1_id;
  logic [LXW-1:0]   r_s1_lx;
  logic [LYW-1:0]   r_s1_ly;

  logic             w_image;

  assign w_x = 32'(CounterX);
  assign w_y = 32'(CounterY);

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      assign w_col_hits[gi] = (w_x >= 32'(X0 + gi*PITCH_X)) && (w_x < 32'(X0 + gi*PITCH_X + PIC_W));
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign w_row_hits[gi] = (w_y >= 32'(Y0 + gi*PITCH_Y)) && (w_y < 32'(Y0 + gi*PITCH_Y + PIC_H));
    end
  endgenerate

  // Pitch >= tile size, so at most one column and one row can hit.
  always_comb begin
    w_col = '0;
    w_lx  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_col_hits[c]) begin
        w_col = 4'(c);
        w_lx  = w_x - 32'(X0 + c*PITCH_X);
      end
    end
    w_row = '0;
    w_ly  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_row_hits[r]) begin
        w_row = 4'(r);
        w_ly  = w_y - 32'(Y0 + r*PITCH_Y);
      end
    end
  end

  assign w_hit   = (|w_col_hits) && (|w_row_hits);
  assign w_id    = 4'(32'(w_row) * 32'(COLS) + 32'(w_col));
  assign w_ind   = w_hit && (w_lx < 32'(IND_SIZE)) && (w_ly < 32'(IND_SIZE));
  // Highlight state is sampled with the pixel, so a coincident frame_start applies to later pixels.
  assign w_hl_on = (|(r_shadow & (N'(1) << w_id))) && (!blink_en || r_blink_phase);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_ind   <= 1'b0;
      r_s1_hl    <= 1'b0;
      r_s1_id    <= '0;
      r_s1_lx    <= '0;
      r_s1_ly    <= '0;
    end else begin
      r_s1_valid <= pix_valid;
      r_s1_hit   <= w_hit;
      r_s1_ind   <= w_ind;
      r_s1_hl    <= w_hl_on;
      r_s1_id    <= w_id;
      r_s1_lx    <= LXW'(w_lx);
      r_s1_ly    <= LYW'(w_ly);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow      <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_start) begin
      r_shadow <= HighlightedProductList;
      if (r_blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_image = r_s1_valid && r_s1_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      isImage     <= 1'b0;
      ImageID     <= '0;
      ROM_Addr    <= '0;
      isHighlight <= 1'b0;
      black_white <= 24'hFFFFFF;
    end else begin
      out_valid   <= r_s1_valid;
      isImage     <= w_image;
      ImageID     <= w_image ? r_s1_id : 4'd0;
      ROM_Addr    <= w_image ? ROM_ADDR_BUS_WIDTH'(32'(r_s1_id) * 32'(PIC_W * PIC_H)
                                                  + 32'(r_s1_ly) * 32'(PIC_W) + 32'(r_s1_lx))
                             : '0;
      isHighlight <= |r_shadow;
      black_white <= (w_image && r_s1_ind && r_s1_hl) ? 24'h0000FF : 24'hFFFFFF;
    end
  end

endmodule

// File: tb/tb_image_grid_locator.sv
// Directed bench for image_grid_locator: addressing, gaps, highlight latching, blink and reset.
module tb_image_grid_locator;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid, frame_start, blink_en;
  logic [9:0]  CounterX, CounterY;
  logic [11:0] HighlightedProductList;
  logic        out_valid, isImage, isHighlight;
  logic [16:0] ROM_Addr;
  logic [3:0]  ImageID;
  logic [23:0] black_white;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [23:0] RED   = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  always #5 clk = ~clk;

  image_grid_locator #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .frame_start(frame_start),
    .CounterX(CounterX), .CounterY(CounterY),
    .HighlightedProductList(HighlightedProductList), .blink_en(blink_en),
    .out_valid(out_valid), .ROM_Addr(ROM_Addr), .isImage(isImage), .ImageID(ImageID),
    .isHighlight(isHighlight), .black_white(black_white)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One pixel in, idle after; returns at the negedge where that pixel's outputs are visible.
  task automatic send_pix(input int x, input int y, input logic fs);
    @(negedge clk);
    CounterX = 10'(x); CounterY = 10'(y); pix_valid = 1'b1; frame_start = fs;
    @(negedge clk);
    pix_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic tile(input string tag, input int x, input int y, input logic img,
                      input int id, input int addr, input logic [23:0] bw);
    send_pix(x, y, 1'b0);
    check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_val({tag, ".img"},   32'(isImage), 32'(img));
    check_val({tag, ".id"},    32'(ImageID), 32'(id));
    check_val({tag, ".addr"},  32'(ROM_Addr), 32'(addr));
    check_val({tag, ".bw"},    32'(black_white), 32'(bw));
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".valid"}, 32'(out_valid), 32'd0);
    check_val({tag, ".img"},   32'(isImage), 32'd0);
    check_val({tag, ".id"},    32'(ImageID), 32'd0);
    check_val({tag, ".addr"},  32'(ROM_Addr), 32'd0);
    check_val({tag, ".hl"},    32'(isHighlight), 32'd0);
    check_val({tag, ".bw"},    32'(black_white), 32'(WHITE));
  endtask

  logic [7:0] blink_tbl;

  initial begin
    reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; blink_en = 1'b0;
    CounterX = '0; CounterY = '0; HighlightedProductList = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // Addressing and tile boundaries
    tile("t0_first",  308,  20, 1'b1,  0,      0, WHITE);
    tile("t0_last",   407, 119, 1'b1,  0,   9999, WHITE);
    tile("t6",        663, 148, 1'b1,  6,  60099, WHITE);
    tile("t11",       692, 276, 1'b1, 11, 110000, WHITE);
    tile("gap_563",   563, 147, 1'b0,  0,      0, WHITE);
    tile("gap_307",   307,  20, 1'b0,  0,      0, WHITE);
    tile("gap_408",   408,  20, 1'b0,  0,      0, WHITE);
    tile("gap_y120",  308, 120, 1'b0,  0,      0, WHITE);

    // Highlight latching, steady mode
    HighlightedProductList = 12'h001;
    tile("hl_pre",    310,  22, 1'b1,  0,    202, WHITE);
    check_val("hl_pre.isHighlight", 32'(isHighlight), 32'd0);
    send_pix(310, 22, 1'b1);
    check_val("hl_coincident.bw", 32'(black_white), 32'(WHITE));
    tile("hl_on",     310,  22, 1'b1,  0,    202, RED);
    check_val("hl_on.isHighlight", 32'(isHighlight), 32'd1);
    tile("hl_outside", 320, 22, 1'b1,  0,    212, WHITE);
    tile("hl_tile4",  310, 150, 1'b1,  4,  40202, WHITE);
    HighlightedProductList = 12'h000;
    tile("hl_latched", 310, 22, 1'b1,  0,    202, RED);
    HighlightedProductList = 12'h001;

    // Asynchronous reset with pixels streaming
    @(negedge clk);
    CounterX = 10'd310; CounterY = 10'd22; pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_val("pre_rst.bw", 32'(black_white), 32'(RED));
    check_val("pre_rst.hl", 32'(isHighlight), 32'd1);
    #1 reset = 1'b1;
    #1 check_reset_vals("rst_async");
    repeat (2) @(negedge clk);
    reset = 1'b0; pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("post_rst.flush", 32'(out_valid), 32'd0);
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    check_val("post_rst.lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("post_rst.lat2", 32'(out_valid), 32'd1);
    check_val("post_rst.img",  32'(isImage), 32'd1);
    check_val("post_rst.bw",   32'(black_white), 32'(WHITE));
    check_val("post_rst.hl",   32'(isHighlight), 32'd0);

    // Blinking with BLINK_FRAMES=2: red on frames 2,3,6,7
    blink_en  = 1'b1;
    blink_tbl = 8'b1100_1100;
    for (int f = 1; f <= 7; f++) begin
      pulse_fs();
      send_pix(310, 22, 1'b0);
      check_val($sformatf("blink_f%0d.bw", f), 32'(black_white),
                blink_tbl[f] ? 32'(RED) : 32'(WHITE));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
